// File: rtl/io_uart_pkg.sv
// io_uart_pkg: register offsets, STATUS/CTRL bit positions and TX FSM encoding
package io_uart_pkg;
    localparam logic [1:0] OFS_TXDATA  = 2'd0;
    localparam logic [1:0] OFS_STATUS  = 2'd1;
    localparam logic [1:0] OFS_BAUDDIV = 2'd2;
    localparam logic [1:0] OFS_CTRL    = 2'd3;
    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 8;
    localparam int CT_TX_EN   = 0;
    localparam int CT_FLUSH   = 1;
    localparam int CT_OVF_CLR = 2;
    localparam int CT_IRQ_EN  = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;
endpackage

// File: rtl/io_uart_tx_resp_if.sv
// io_uart_tx_resp_if: dma_io bus (word write port, registered read port)
// master = CPU side, slave = IO responder
interface io_uart_tx_resp_if;
    logic        dma_io_we;
    logic [13:0] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [13:0] dma_io_radr;
    logic        dma_io_radr_en;
    logic [31:0] dma_io_rdata;
    modport master (output dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en, input dma_io_rdata);
    modport slave (input dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en, output dma_io_rdata);
endinterface

// File: rtl/io_uart_fifo.sv
// io_uart_fifo: byte FIFO with wrap-bit pointers
// ports: clk, rst_n (async low), push/din, pop/dout (show-ahead), flush, full, empty, count
module io_uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        do_push, do_pop;
    assign count   = wptr - rptr;
    assign empty   = wptr == rptr;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop & !empty;
    // a pop frees the slot this cycle, so a push into a full FIFO is still accepted
    assign do_push = push & (!full | do_pop);
    assign dout    = mem[rptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push & !flush) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/io_uart_tx_resp.sv
// io_uart_tx_resp: dma_io register window + TX FIFO + 8N1 UART transmitter
// ports: clk, rst_n (async low), bus (dma_io slave), uart_tx (idle high),
//        uart_irq (only when IO_UART_IRQ_EN is defined)
module io_uart_tx_resp
    import io_uart_pkg::*;
#(
    parameter logic [13:0] IO_BASE      = 14'h0040,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] BAUD_DEFAULT = 16'd434
) (
    input  logic               clk,
    input  logic               rst_n,
    io_uart_tx_resp_if.slave   bus,
`ifdef IO_UART_IRQ_EN
    output logic               uart_irq,
`endif
    output logic               uart_tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [13:0]   woff, roff;
    logic          wsel, rsel, wr_tx, wr_baud, wr_ctrl, flush;
    logic [15:0]   baud_div, cnt;
    logic          tx_en, ovf, irq_en;
    logic [7:0]    dout, sh;
    logic          full, empty;
    logic [CW-1:0] count;
    logic [31:0]   status, ctrl_rd, rd_val, rdata_q;
    tx_state_t     state, state_n;
    logic [2:0]    idx;
    logic          tick, pop, busy, tx_d;
    logic          unused_bits;
    assign unused_bits = ^{bus.dma_io_wdata[31:16], bus.dma_io_wdata[3]};
    // offsets wrap below IO_BASE, so one compare of the upper bits bounds the window
    assign woff    = bus.dma_io_wadr - IO_BASE;
    assign roff    = bus.dma_io_radr - IO_BASE;
    assign wsel    = bus.dma_io_we & (woff[13:2] == '0);
    assign rsel    = bus.dma_io_radr_en & (roff[13:2] == '0);
    assign wr_tx   = wsel & (woff[1:0] == OFS_TXDATA);
    assign wr_baud = wsel & (woff[1:0] == OFS_BAUDDIV);
    assign wr_ctrl = wsel & (woff[1:0] == OFS_CTRL);
    assign flush   = wr_ctrl & bus.dma_io_wdata[CT_FLUSH];
    io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_tx),
        .pop   (pop),
        .flush (flush),
        .din   (bus.dma_io_wdata[7:0]),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_div <= BAUD_DEFAULT;
            tx_en    <= 1'b1;
            ovf      <= 1'b0;
        end else begin
            if (wr_baud) baud_div <= bus.dma_io_wdata[15:0];
            if (wr_ctrl) tx_en <= bus.dma_io_wdata[CT_TX_EN];
            if (wr_ctrl & bus.dma_io_wdata[CT_OVF_CLR]) ovf <= 1'b0;
            else if (wr_tx & full & !pop & !flush) ovf <= 1'b1;
        end
    end
`ifdef IO_UART_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en   <= 1'b0;
            uart_irq <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= bus.dma_io_wdata[CT_IRQ_EN];
            uart_irq <= irq_en & empty & !busy;
        end
    end
`else
    assign irq_en = 1'b0;
`endif
    always_comb begin
        status = '0;
        status[ST_BUSY] = busy;
        status[ST_FULL] = full;
        status[ST_EMPTY] = empty;
        status[ST_OVF] = ovf;
        status[ST_COUNT +: CW] = count;
        ctrl_rd = '0;
        ctrl_rd[CT_TX_EN] = tx_en;
        ctrl_rd[CT_IRQ_EN] = irq_en;
        rd_val = roff[1:0] == OFS_STATUS ? status :
                 roff[1:0] == OFS_BAUDDIV ? {16'h0, baud_div} :
                 roff[1:0] == OFS_CTRL ? ctrl_rd : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else rdata_q <= rsel ? rd_val : '0;
    end
    assign bus.dma_io_rdata = rdata_q;
    assign tick = cnt == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = pop ? START : IDLE;
            START:   state_n = tick ? DATA : START;
            DATA:    state_n = tick && idx == 3'd7 ? STOP : DATA;
            default: state_n = tick ? IDLE : STOP;
        endcase
    end
    // tx_d is the line level for the next cycle, so uart_tx changes together with the state
    always_comb begin
        busy = state != IDLE;
        pop  = state == IDLE & tx_en & !empty;
        tx_d = state_n == START ? 1'b0 :
               state_n == DATA ? (state == DATA & tick ? sh[1] : sh[0]) : 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sh      <= '0;
            idx     <= '0;
            uart_tx <= 1'b1;
        end else begin
            uart_tx <= tx_d;
            if (pop) begin
                sh  <= dout;
                cnt <= baud_div;
            end else if (busy) begin
                cnt <= tick ? baud_div : cnt - 1'b1;
                if (tick & state == DATA) begin
                    sh  <= sh >> 1;
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_io_uart_tx_resp.sv
// tb_io_uart_tx_resp: directed tests for the UART TX responder
module tb_io_uart_tx_resp;
    localparam logic [13:0] A_TX = 14'h0040;
    localparam logic [13:0] A_ST = 14'h0041;
    localparam logic [13:0] A_BD = 14'h0042;
    localparam logic [13:0] A_CT = 14'h0043;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_tx;
`ifdef IO_UART_IRQ_EN
    logic uart_irq;
`endif
    int total = 0;
    int bad = 0;
    io_uart_tx_resp_if bus();
    io_uart_tx_resp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
`ifdef IO_UART_IRQ_EN
        .uart_irq (uart_irq),
`endif
        .uart_tx  (uart_tx)
    );
    always #5 clk = ~clk;

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        bus.dma_io_we = 1'b1;
        bus.dma_io_wadr = a;
        bus.dma_io_wdata = d;
        @(negedge clk);
        bus.dma_io_we = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] d);
        bus.dma_io_radr = a;
        bus.dma_io_radr_en = 1'b1;
        @(negedge clk);
        bus.dma_io_radr_en = 1'b0;
        d = bus.dma_io_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
        total++; if (bus.dma_io_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.dma_io_rdata); end
`ifdef IO_UART_IRQ_EN
        total++; if (uart_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", uart_irq); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        rd(A_ST, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL reset_status got=%h exp=%h", d, 32'h4); end
        rd(A_BD, d);
        total++; if (d !== 32'h1B2) begin bad++; $display("FAIL reset_bauddiv got=%h exp=%h", d, 32'h1B2); end
        rd(A_CT, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", d, 32'h1); end
        rd(A_TX, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL txdata_read got=%h exp=0", d); end
    endtask

    task automatic test_frame();
        logic [31:0] d;
        logic [9:0] pat;
        int n;
        pat = {1'b1, 8'h55, 1'b0};
        wr(A_BD, 32'd3);
        wr(A_TX, 32'h55);
        n = 0;
        while (uart_tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        total++; if (n !== 1) begin bad++; $display("FAIL start_latency got=%0d exp=1", n); end
        for (int i = 0; i < 40; i++) begin
            total++; if (uart_tx !== pat[i/4]) begin bad++; $display("FAIL frame_bit%0d got=%b exp=%b", i, uart_tx, pat[i/4]); end
            if (i == 20) begin bus.dma_io_radr = A_ST; bus.dma_io_radr_en = 1'b1; end
            if (i == 21) begin
                bus.dma_io_radr_en = 1'b0;
                total++; if (bus.dma_io_rdata !== 32'h5) begin bad++; $display("FAIL busy_status got=%h exp=%h", bus.dma_io_rdata, 32'h5); end
            end
            @(negedge clk);
        end
        rd(A_ST, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL idle_status got=%h exp=%h", d, 32'h4); end
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL idle_tx got=%b exp=1", uart_tx); end
        rd(A_BD, d);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL bauddiv_rw got=%h exp=3", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        wr(A_CT, 32'h0);
        for (int i = 0; i < 9; i++) wr(A_TX, 32'hA0 + 32'(i));
        rd(A_ST, d);
        total++; if (d !== 32'h80A) begin bad++; $display("FAIL ovf_status got=%h exp=%h", d, 32'h80A); end
        rd(A_CT, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ctrl_txen0 got=%h exp=0", d); end
        wr(A_CT, 32'h4);
        rd(A_ST, d);
        total++; if (d !== 32'h802) begin bad++; $display("FAIL ovf_clr_status got=%h exp=%h", d, 32'h802); end
    endtask

    task automatic test_full_push();
        logic [31:0] d;
        wr(A_CT, 32'h1);
        wr(A_TX, 32'hEE);
        rd(A_ST, d);
        total++; if (d !== 32'h803) begin bad++; $display("FAIL push_pop_full got=%h exp=%h", d, 32'h803); end
        wr(A_CT, 32'h2);
        for (int k = 0; k < 200; k++) begin
            rd(A_ST, d);
            if (d[0] === 1'b0) break;
        end
        total++; if (d !== 32'h4) begin bad++; $display("FAIL flush_drain got=%h exp=%h", d, 32'h4); end
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL flush_tx got=%b exp=1", uart_tx); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int n;
        int hits;
        wr(A_CT, 32'h1);
        wr(A_TX, 32'h00);
        n = 0;
        while (uart_tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        total++; if (n !== 1) begin bad++; $display("FAIL mid_start got=%0d exp=1", n); end
        repeat (16) @(negedge clk);
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL mid_bit3 got=%b exp=0", uart_tx); end
        rst_n = 1'b0;
        #1;
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL async_abort got=%b exp=1", uart_tx); end
        @(negedge clk);
        rst_n = 1'b1;
        rd(A_ST, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL post_reset_status got=%h exp=%h", d, 32'h4); end
        hits = 0;
        for (int i = 0; i < 60; i++) begin
            if (uart_tx !== 1'b1) hits++;
            @(negedge clk);
        end
        total++; if (hits !== 0) begin bad++; $display("FAIL no_frame got=%0d exp=0", hits); end
        rd(A_BD, d);
        total++; if (d !== 32'h1B2) begin bad++; $display("FAIL post_reset_baud got=%h exp=%h", d, 32'h1B2); end
    endtask

    task automatic test_window();
        logic [31:0] d;
        rd(14'h0045, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rd_above got=%h exp=0", d); end
        rd(14'h003F, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rd_below got=%h exp=0", d); end
        wr(14'h0046, 32'h7);
        wr(14'h0047, 32'h0);
        wr(14'h0044, 32'h12);
        wr(14'h003C, 32'h34);
        rd(A_BD, d);
        total++; if (d !== 32'h1B2) begin bad++; $display("FAIL wr_out_baud got=%h exp=%h", d, 32'h1B2); end
        rd(A_CT, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL wr_out_ctrl got=%h exp=1", d); end
        rd(A_ST, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL wr_out_status got=%h exp=%h", d, 32'h4); end
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] d;
        logic [31:0] exp_ct;
        bus.dma_io_we = 1'b1;
        bus.dma_io_wadr = A_BD;
        bus.dma_io_wdata = 32'h9;
        bus.dma_io_radr = A_BD;
        bus.dma_io_radr_en = 1'b1;
        @(negedge clk);
        bus.dma_io_we = 1'b0;
        bus.dma_io_radr_en = 1'b0;
        total++; if (bus.dma_io_rdata !== 32'h1B2) begin bad++; $display("FAIL rw_pre_write got=%h exp=%h", bus.dma_io_rdata, 32'h1B2); end
        @(negedge clk);
        total++; if (bus.dma_io_rdata !== 32'h0) begin bad++; $display("FAIL rdata_idle got=%h exp=0", bus.dma_io_rdata); end
        rd(A_BD, d);
        total++; if (d !== 32'h9) begin bad++; $display("FAIL rw_post_write got=%h exp=9", d); end
        wr(A_CT, 32'h9);
        rd(A_CT, d);
`ifdef IO_UART_IRQ_EN
        exp_ct = 32'h9;
`else
        exp_ct = 32'h1;
`endif
        total++; if (d !== exp_ct) begin bad++; $display("FAIL ctrl_bit3 got=%h exp=%h", d, exp_ct); end
        wr(A_CT, 32'h1);
    endtask

    initial begin
        bus.dma_io_we = 1'b0;
        bus.dma_io_wadr = '0;
        bus.dma_io_wdata = '0;
        bus.dma_io_radr = '0;
        bus.dma_io_radr_en = 1'b0;
        test_reset();
        test_frame();
        test_overflow();
        test_full_push();
        test_reset_mid();
        test_window();
        test_rw_same_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
